// File: rtl/sips4_ram_arbiter.sv
// Two-port req/gnt arbiter in front of the SIPS4 16x4 data RAM (core port 0, loader port 1).
// Define SIPS4_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module sips4_ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {
    IDLE,
    RD_ADDR
  } state_t;

  state_t        state;
  logic          rd_port;
  logic          ready;
  logic          win0;
  logic          accept;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifndef SIPS4_ARB_FIXED_PRIO_EN
  logic          rr_last;
`endif

  // win0 says who takes a conflict: port 0 unless it was the last port served.
  always_comb begin
    ready = (state == IDLE) && !rst;
`ifdef SIPS4_ARB_FIXED_PRIO_EN
    win0  = 1'b1;
`else
    win0  = rr_last;
`endif
    gnt0      = ready && req0 && (!req1 || win0);
    gnt1      = ready && req1 && (!req0 || !win0);
    accept    = gnt0 || gnt1;
    sel       = gnt1;
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

  assign rdata = ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_port   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_raddr <= '0;
      ram_wdata <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
`ifndef SIPS4_ARB_FIXED_PRIO_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      ram_wen <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ram_waddr <= sel_addr;
            ram_raddr <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_wen   <= sel_we;
`ifndef SIPS4_ARB_FIXED_PRIO_EN
            rr_last   <= sel;
`endif
            if (!sel_we) begin
              state   <= RD_ADDR;
              rd_port <= sel;
            end
          end
        end
        // RAM is sampling ram_raddr this cycle; its q appears next cycle with the strobe.
        RD_ADDR: begin
          state   <= IDLE;
          rvalid0 <= !rd_port;
          rvalid1 <= rd_port;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
